// File: rtl/sequential_divider_if.sv
// rtl/sequential_divider_if.sv - operand/result bundle for sequential_divider
interface sequential_divider_if #(
   parameter int N = 4
);
   logic         start;
   logic [N-1:0] Q;
   logic [N-1:0] M;
   logic         busy;
   logic         done;
   logic [N-1:0] Zq;
   logic [N-1:0] Zr;
   logic         dbz;

   modport master (output start, Q, M, input busy, done, Zq, Zr, dbz);
   modport slave  (input start, Q, M, output busy, done, Zq, Zr, dbz);
endinterface

// File: rtl/sequential_divider.sv
// rtl/sequential_divider.sv - iterative restoring divider, one quotient bit per clock
// SEQ_DIV_SIGNED_EN: two's complement operands around the same unsigned core
module sequential_divider #(
   parameter int N = 4
) (
   input  logic                C,
   input  logic                rst_n,
   sequential_divider_if.slave bus
);
   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

   state_t         r_state;
   state_t         w_next;
   logic [N:0]     r_a;
   logic [N-1:0]   r_qr;
   logic [N-1:0]   r_mr;
   logic [CW-1:0]  r_count;
   logic           r_dbz_path;
   logic           r_busy;
   logic           r_done;
   logic [N-1:0]   r_zq;
   logic [N-1:0]   r_zr;
   logic           r_dbz;

   logic           w_last;
   logic           w_m_zero;
   logic [2*N:0]   w_shift;
   logic [N:0]     w_a_sh;
   logic [N:0]     w_t;
   logic [N-1:0]   w_q_in;
   logic [N-1:0]   w_m_in;
   logic [N-1:0]   w_zq_fin;
   logic [N-1:0]   w_zr_fin;

   assign w_last   = (r_count == CW'(N - 1));
   assign w_m_zero = (bus.M == '0);
   assign w_shift  = {r_a, r_qr} << 1;
   assign w_a_sh   = w_shift[2*N:N];
   assign w_t      = w_a_sh - {1'b0, r_mr};

`ifdef SEQ_DIV_SIGNED_EN
   logic r_sq;
   logic r_sm;

   // Core sees magnitudes; the most-negative value's magnitude still fits unsigned N bits
   assign w_q_in   = bus.Q[N-1] ? -bus.Q : bus.Q;
   assign w_m_in   = bus.M[N-1] ? -bus.M : bus.M;
   assign w_zq_fin = (r_sq ^ r_sm) ? -r_qr : r_qr;
   assign w_zr_fin = r_sq ? -r_a[N-1:0] : r_a[N-1:0];

   always_ff @(posedge C or negedge rst_n) begin
      if (!rst_n) begin
         r_sq <= 1'b0;
         r_sm <= 1'b0;
      end else if (r_state == S_IDLE && bus.start) begin
         r_sq <= bus.Q[N-1];
         r_sm <= bus.M[N-1];
      end
   end
`else
   assign w_q_in   = bus.Q;
   assign w_m_in   = bus.M;
   assign w_zq_fin = r_qr;
   assign w_zr_fin = r_a[N-1:0];
`endif

   always_ff @(posedge C or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (bus.start) w_next = w_m_zero ? S_FIN : S_RUN;
         S_RUN:   if (w_last) w_next = S_FIN;
         S_FIN:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge C or negedge rst_n) begin
      if (!rst_n) begin
         r_a        <= '0;
         r_qr       <= '0;
         r_mr       <= '0;
         r_count    <= '0;
         r_dbz_path <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_zq       <= '0;
         r_zr       <= '0;
         r_dbz      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  // Divide-by-zero keeps the raw dividend so it can be returned as remainder
                  r_qr       <= w_m_zero ? bus.Q : w_q_in;
                  r_mr       <= w_m_in;
                  r_a        <= '0;
                  r_count    <= '0;
                  r_dbz_path <= w_m_zero;
                  r_busy     <= !w_m_zero;
               end
            end
            S_RUN: begin
               r_a     <= w_t[N] ? w_a_sh : w_t;
               r_qr    <= w_shift[N-1:0] | {{(N-1){1'b0}}, ~w_t[N]};
               r_count <= r_count + 1'b1;
            end
            S_FIN: begin
               r_done <= 1'b1;
               r_busy <= 1'b0;
               if (r_dbz_path) begin
                  r_zq  <= '1;
                  r_zr  <= r_qr;
                  r_dbz <= 1'b1;
               end else begin
                  r_zq  <= w_zq_fin;
                  r_zr  <= w_zr_fin;
                  r_dbz <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.Zq   = r_zq;
   assign bus.Zr   = r_zr;
   assign bus.dbz  = r_dbz;
endmodule

// File: doc/sequential_divider.md
# sequential_divider

Iterative restoring divider; the inverse companion of the `sequential_multiplier`. It accepts an N-bit dividend and an N-bit divisor on a start pulse and resolves one quotient bit per clock. It returns quotient and remainder with a one-cycle done pulse. It sits beside the multiplier in the arithmetic datapath and shares its operand naming (M, Q).

## Interface
- N, default 4: operand, quotient and remainder width (N ≥ 2).

- C  input  1  clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- Q  input  N  dividend, latched on the accepted start.
- M  input  N  divisor, latched on the accepted start.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse; result valid.
- Zq  output  N  quotient, held until the next completion.
- Zr  output  N  remainder, held until the next completion.
- dbz  output  1  divide-by-zero flag, updated at each completion.

## Operation
- Reset (rst_n=0, asynchronous):
  - state goes to IDLE.
  - busy=0, done=0, dbz=0, Zq=0, Zr=0.
  - internal A, Qr and count are cleared.
- States: IDLE, RUN, FIN.
- IDLE:
  - start=1 and M≠0: latch Qr←Q, Mr←M, A←0 (N+1 bits), count←0; go to RUN; busy←1.
  - start=1 and M=0: go to FIN with the divide-by-zero path selected.
  - start=0: stay in IDLE.
- RUN, one iteration per edge:
  - {A,Qr}←{A,Qr}<<1.
  - T=A−{0,Mr}.
  - If T is negative (MSB=1): A is unchanged after the shift, Qr[0]←0.
  - Otherwise: A←T, Qr[0]←1.
  - count←count+1.
  - After the Nth iteration, go to FIN.
- FIN (one cycle):
  - Normal path: Zq←Qr, Zr←A[N-1:0], dbz←0.
  - Divide-by-zero path: Zq←all ones, Zr←latched Q, dbz←1.
  - done←1, busy←0; go to IDLE.
- done is a registered pulse and is exactly one cycle wide.
- start is ignored while busy=1 or in FIN. It is not queued.
- Operands may change after acceptance without affecting the result.
- Unsigned results satisfy Q = Zq·M + Zr with Zr < M.

## Timing
- The start edge is edge k.
- Normal division:
  - busy is high after edge k.
  - RUN iterations occur on edges k+1 … k+N.
  - FIN occurs on edge k+N+1, where done=1 and results update.
  - busy falls at edge k+N+1.
  - Latency from start to done is N+1 cycles (5 for N=4).
- Divide by zero: done=1 after edge k+1 (latency 1); busy never rises.
- Back-to-back: start may be asserted in the cycle done is high. It is accepted at the next edge, giving throughput of one result per N+2 cycles.
- Reset mid-RUN aborts immediately. done is not asserted and Zq/Zr are cleared.

## Configuration
- Macro: SEQ_DIV_SIGNED_EN.
- Defined: Q and M are two's complement.
  - Magnitudes are latched at start and the unsigned core runs unchanged.
  - In FIN, Zq is negated if sign(Q)≠sign(M), and Zr takes the sign of Q.
  - Truncation is toward zero.
  - The most-negative ÷ −1 case wraps: Zq = most negative, Zr=0.
  - Divide-by-zero result is the same as unsigned.
  - Latency is unchanged.
- Not defined: all operands are unsigned and no sign logic is synthesized.

## Test plan
- Reset, then Q=4'b1101 (13), M=4'b0011 (3), start 1 cycle -> busy for 5 cycles; done pulse 5 cycles after start; Zq=4, Zr=1, dbz=0.
- Q=13, M=13, then Q=2, M=7 back-to-back (second start during the done cycle) -> Zq=1/Zr=0, then Zq=0/Zr=2, done pulses 6 cycles apart.
- Q=5, M=0 -> done 1 cycle after start; Zq=4'hF, Zr=5, dbz=1, busy stays 0.
- Q=15, M=2 started; start re-pulsed with Q=1, M=1 on RUN cycle 2 -> the second start is ignored; result Zq=7, Zr=1; exactly one done pulse.
- Q=9, M=4 started; rst_n low for 1 cycle on RUN cycle 3 -> busy=0, done never asserts, Zq=Zr=0; a fresh 9/4 afterwards gives Zq=2, Zr=1.
- With SEQ_DIV_SIGNED_EN: Q=−7 (4'b1001), M=2 -> Zq=−3 (4'b1101), Zr=−1 (4'b1111). Q=−8, M=−1 -> Zq=4'b1000, Zr=0.
